// File: rtl/adis_pkg.sv
// Shared types and constants for the ADIS IMU read sequencer: register
// address table, SPI read-command format and the sequencer state encoding.
package adis_pkg;

    localparam int REG_W   = 16;
    localparam int N_TABLE = 6;

    localparam logic [5:0] ADDR_GYRO_X = 6'h04;
    localparam logic [5:0] ADDR_GYRO_Y = 6'h06;
    localparam logic [5:0] ADDR_GYRO_Z = 6'h08;
    localparam logic [5:0] ADDR_ACCL_X = 6'h0A;
    localparam logic [5:0] ADDR_ACCL_Y = 6'h0C;
    localparam logic [5:0] ADDR_ACCL_Z = 6'h0E;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STALL,
        PUBLISH
    } state_t;

    // Frame slot index to register address, gyro first then accel.
    function automatic logic [5:0] reg_addr(input int idx);
        case (idx)
            0:       return ADDR_GYRO_X;
            1:       return ADDR_GYRO_Y;
            2:       return ADDR_GYRO_Z;
            3:       return ADDR_ACCL_X;
            4:       return ADDR_ACCL_Y;
            5:       return ADDR_ACCL_Z;
            default: return ADDR_GYRO_X;
        endcase
    endfunction

    function automatic logic [REG_W-1:0] cmd(input logic [5:0] addr);
        return {2'b00, addr, 8'h00};
    endfunction

endpackage

// File: rtl/adis_drdy_sync.sv
// Two-flop synchronizer for the asynchronous IMU data-ready pin, followed by
// a rising-edge detector on the synchronized level.
module adis_drdy_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic drdy,
    output logic drdy_rise
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= drdy;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign drdy_rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/adis_read_sequencer.sv
// Frame-level read sequencer: one pipelined burst of N_REGS+1 SPI reads per
// data-ready edge, stall-time enforcement, timeout abort and atomic publish.
module adis_read_sequencer
    import adis_pkg::*;
#(
    parameter int N_REGS         = 6,
    parameter int STALL_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      drdy,
    input  logic                      err_clr,
    output logic                      spi_start,
    output logic [REG_W-1:0]          spi_tx,
    input  logic                      spi_done,
    input  logic [REG_W-1:0]          spi_rx,
    output logic [REG_W*N_REGS-1:0]   frame_data,
    output logic                      frame_valid,
    output logic [15:0]               frame_count,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int K_W     = $clog2(N_REGS + 1);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > STALL_CYCLES) ? TIMEOUT_CYCLES : STALL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [K_W-1:0]   K_LAST       = K_W'(N_REGS);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // START itself is one of the idle clocks, so STALL lasts STALL_CYCLES-1.
    localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);

    logic drdy_rise;

    state_t                          state_q, state_d;
    logic [K_W-1:0]                  k_q, k_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [N_REGS-1:0][REG_W-1:0]    shadow_q, shadow_d;
    logic [N_REGS-1:0][REG_W-1:0]    frame_q, frame_d;
    logic                            spi_start_q, spi_start_d;
    logic [REG_W-1:0]                spi_tx_q, spi_tx_d;
    logic                            frame_valid_q, frame_valid_d;
    logic [15:0]                     frame_count_q, frame_count_d;
    logic                            busy_q, busy_d;
    logic                            overrun_q, overrun_d;
    logic                            timeout_err_q, timeout_err_d;

    adis_drdy_sync u_drdy_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .drdy      (drdy),
        .drdy_rise (drdy_rise)
    );

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        spi_start_d   = 1'b0;
        spi_tx_d      = spi_tx_q;
        frame_valid_d = 1'b0;
        frame_count_d = frame_count_q;
        busy_d        = busy_q;
        overrun_d     = overrun_q;
        timeout_err_d = timeout_err_q;

        // Clear first so that an error raised in the same cycle wins.
        if (err_clr) begin
            overrun_d     = 1'b0;
            timeout_err_d = 1'b0;
        end
        if (drdy_rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                k_d = '0;
                if (drdy_rise && enable) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                spi_start_d = 1'b1;
                spi_tx_d    = cmd(reg_addr((k_q == K_LAST) ? 0 : int'(k_q)));
                cnt_d       = '0;
                state_d     = WAIT;
            end

            WAIT: begin
                if (spi_done) begin
                    // The IMU answers the previous command; transfer 0 returns junk.
                    if (k_q != '0) begin
                        shadow_d[k_q - K_W'(1)] = spi_rx;
                    end
                    if (k_q == K_LAST) begin
                        frame_d       = shadow_d;
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                        state_d       = PUBLISH;
                    end else begin
                        k_d     = k_q + K_W'(1);
                        cnt_d   = '0;
                        state_d = (STALL_CYCLES > 1) ? STALL : START;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    shadow_d      = '0;
                    k_d           = '0;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STALL: begin
                if (cnt_q == STALL_LAST) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PUBLISH: begin
                k_d     = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            k_q           <= '0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            spi_start_q   <= 1'b0;
            spi_tx_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            spi_start_q   <= spi_start_d;
            spi_tx_q      <= spi_tx_d;
            frame_valid_q <= frame_valid_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    for (genvar gi = 0; gi < N_REGS; gi++) begin : g_frame_out
        assign frame_data[REG_W*gi +: REG_W] = frame_q[gi];
    end

    assign spi_start   = spi_start_q;
    assign spi_tx      = spi_tx_q;
    assign frame_valid = frame_valid_q;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adis_read_sequencer.sv
// Directed bench for adis_read_sequencer with a pipelined SPI master model
// that answers transfer n of a frame with 0x1000+n two cycles after spi_start.
module tb_adis_read_sequencer;

    localparam int NR  = 6;
    localparam int STL = 16;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          drdy = 1'b0;
    logic          err_clr = 1'b0;
    logic          spi_done = 1'b0;
    logic [15:0]   spi_rx = 16'h0000;
    logic          spi_start;
    logic [15:0]   spi_tx;
    logic [16*NR-1:0] frame_data;
    logic          frame_valid;
    logic [15:0]   frame_count;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    adis_read_sequencer #(
        .N_REGS         (NR),
        .STALL_CYCLES   (STL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .drdy        (drdy),
        .err_clr     (err_clr),
        .spi_start   (spi_start),
        .spi_tx      (spi_tx),
        .spi_done    (spi_done),
        .spi_rx      (spi_rx),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    logic [15:0] exp_tx [7] = '{16'h0400, 16'h0600, 16'h0800, 16'h0A00, 16'h0C00, 16'h0E00, 16'h0400};

    // SPI master model
    int xfer_n = 0;
    int withhold = -1;
    int start_cyc [8];
    int done_cyc [8];
    logic [15:0] tx_log [8];

    initial begin
        int idx;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                idx = xfer_n;
                xfer_n = xfer_n + 1;
                if (idx < 8) begin
                    start_cyc[idx] = cyc;
                    tx_log[idx] = spi_tx;
                end
                if (idx != withhold) begin
                    repeat (2) @(negedge clk);
                    spi_done = 1'b1;
                    spi_rx = 16'h1000 + 16'(idx);
                    if (idx < 8) done_cyc[idx] = cyc;
                    @(negedge clk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    int fv_count = 0;
    int st_count = 0;
    int fv_cyc = 0;
    logic busy_at_fv = 1'b0;
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count   <= fv_count + 1;
            fv_cyc     <= cyc;
            busy_at_fv <= busy;
        end
        if (spi_start === 1'b1) st_count <= st_count + 1;
    end

    task automatic pulse_drdy(output int t);
        @(negedge clk);
        drdy = 1'b1;
        t = cyc + 1;
        repeat (3) @(negedge clk);
        drdy = 1'b0;
    endtask

    task automatic wait_frame(input int old, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fv_count != old) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_xfer(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (xfer_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_err_clr;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (spi_start !== 1'b0) begin failures++; $display("FAIL reset_spi_start got=%0b exp=0", spi_start); end
        checks++; if (spi_tx !== 16'h0000) begin failures++; $display("FAIL reset_spi_tx got=%h exp=0000", spi_tx); end
        checks++; if (frame_data !== '0) begin failures++; $display("FAIL reset_frame_data got=%h exp=0", frame_data); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid got=%0b exp=0", frame_valid); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0b exp=0", timeout_err); end
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        $display("reset: outputs at reset values checked");
    endtask

    task automatic test_single_frame;
        int t, old;
        bit ok;
        old = fv_count;
        xfer_n = 0;
        pulse_drdy(t);
        wait_frame(old, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_frame_timeout got=no_frame_valid exp=frame_valid"); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%0b exp=0 at cyc %0d (fv at %0d)", busy, cyc, fv_cyc); end
        checks++; if (busy_at_fv !== 1'b1) begin failures++; $display("FAIL single_busy_at_fv got=%0b exp=1", busy_at_fv); end
        checks++; if (start_cyc[0] - t !== 3) begin failures++; $display("FAIL drdy_latency got=%0d exp=3", start_cyc[0] - t); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL spi_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            checks++; if (start_cyc[i+1] - done_cyc[i] !== STL + 1) begin failures++; $display("FAIL stall_gap[%0d] got=%0d exp=%0d", i, start_cyc[i+1] - done_cyc[i], STL + 1); end
        end
        for (int i = 0; i < NR; i++) begin
            checks++; if (frame_data[16*i +: 16] !== 16'h1001 + 16'(i)) begin failures++; $display("FAIL single_word[%0d] got=%h exp=%h", i, frame_data[16*i +: 16], 16'h1001 + 16'(i)); end
        end
        checks++; if (fv_cyc - done_cyc[6] !== 1) begin failures++; $display("FAIL fv_latency got=%0d exp=1", fv_cyc - done_cyc[6]); end
        exp_count = exp_count + 1;
        repeat (30) @(negedge clk);
        checks++; if (fv_count !== old + 1) begin failures++; $display("FAIL single_fv_count got=%0d exp=%0d", fv_count - old, 1); end
        checks++; if (frame_count !== 16'(exp_count)) begin failures++; $display("FAIL single_frame_count got=%0d exp=%0d", frame_count, exp_count); end
        $display("frame: single frame count=%0d word0=%h word5=%h", frame_count, frame_data[15:0], frame_data[95:80]);
    endtask

    task automatic test_overrun;
        int t, t2, old, st0;
        bit ok;
        old = fv_count;
        st0 = st_count;
        xfer_n = 0;
        pulse_drdy(t);
        wait_xfer(4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL overrun_xfer3_timeout got=%0d exp>=4", xfer_n); end
        pulse_drdy(t2);
        wait_frame(old, ok);
        checks++; if (!ok) begin failures++; $display("FAIL overrun_frame_timeout got=no_frame_valid exp=frame_valid"); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%0b exp=1", overrun); end
        for (int i = 0; i < NR; i++) begin
            checks++; if (frame_data[16*i +: 16] !== 16'h1001 + 16'(i)) begin failures++; $display("FAIL overrun_word[%0d] got=%h exp=%h", i, frame_data[16*i +: 16], 16'h1001 + 16'(i)); end
        end
        exp_count = exp_count + 1;
        repeat (40) @(negedge clk);
        checks++; if (fv_count !== old + 1) begin failures++; $display("FAIL overrun_one_frame got=%0d exp=1", fv_count - old); end
        checks++; if (st_count !== st0 + 7) begin failures++; $display("FAIL overrun_transfers got=%0d exp=7", st_count - st0); end
        checks++; if (frame_count !== 16'(exp_count)) begin failures++; $display("FAIL overrun_frame_count got=%0d exp=%0d", frame_count, exp_count); end
        pulse_err_clr();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%0b exp=0", overrun); end
        $display("frame: overrun frame count=%0d overrun cleared", frame_count);
    endtask

    task automatic test_timeout;
        int t, s, old, st0;
        bit ok;
        old = fv_count;
        st0 = st_count;
        withhold = 2;
        xfer_n = 0;
        pulse_drdy(t);
        wait_xfer(3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_xfer2_timeout got=%0d exp>=3", xfer_n); end
        s = start_cyc[2];
        while (cyc < s + TMO - 1) @(negedge clk);
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_early got=%0b exp=0 at +%0d", timeout_err, cyc - s); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%0b exp=1 at +%0d", timeout_err, cyc - s); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
        repeat (20) @(negedge clk);
        checks++; if (fv_count !== old) begin failures++; $display("FAIL timeout_no_frame got=%0d exp=0", fv_count - old); end
        checks++; if (st_count !== st0 + 3) begin failures++; $display("FAIL timeout_transfers got=%0d exp=3", st_count - st0); end
        checks++; if (frame_count !== 16'(exp_count)) begin failures++; $display("FAIL timeout_frame_count got=%0d exp=%0d", frame_count, exp_count); end
        for (int i = 0; i < NR; i++) begin
            checks++; if (frame_data[16*i +: 16] !== 16'h1001 + 16'(i)) begin failures++; $display("FAIL timeout_word[%0d] got=%h exp=%h", i, frame_data[16*i +: 16], 16'h1001 + 16'(i)); end
        end
        withhold = -1;
        pulse_err_clr();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%0b exp=0", timeout_err); end
        $display("frame: aborted by timeout, frame_data retained");
    endtask

    task automatic test_enable_drop;
        int t, old;
        bit ok;
        old = fv_count;
        xfer_n = 0;
        pulse_drdy(t);
        wait_xfer(2, ok);
        enable = 1'b0;
        wait_frame(old, ok);
        checks++; if (!ok) begin failures++; $display("FAIL enable_drop_frame got=no_frame_valid exp=frame_valid"); end
        exp_count = exp_count + 1;
        @(negedge clk);
        checks++; if (frame_count !== 16'(exp_count)) begin failures++; $display("FAIL enable_drop_count got=%0d exp=%0d", frame_count, exp_count); end
        checks++; if (frame_data[95:80] !== 16'h1006) begin failures++; $display("FAIL enable_drop_word5 got=%h exp=1006", frame_data[95:80]); end
        $display("frame: enable dropped mid-frame, count=%0d", frame_count);
    endtask

    task automatic test_enable_off;
        int t, st0;
        enable = 1'b0;
        st0 = st_count;
        for (int i = 0; i < 3; i++) begin
            pulse_drdy(t);
            repeat (4) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (st_count !== st0) begin failures++; $display("FAIL enable_off_start got=%0d exp=0", st_count - st0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL enable_off_busy got=%0b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL enable_off_overrun got=%0b exp=0", overrun); end
        enable = 1'b1;
        $display("drdy: three pulses with enable low ignored");
    endtask

    task automatic test_midframe_reset;
        int t, s, old;
        bit ok;
        xfer_n = 0;
        pulse_drdy(t);
        wait_xfer(5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midreset_xfer4_timeout got=%0d exp>=5", xfer_n); end
        s = start_cyc[4];
        while (cyc < s + 6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (spi_start !== 1'b0) begin failures++; $display("FAIL midreset_spi_start got=%0b exp=0", spi_start); end
        checks++; if (spi_tx !== 16'h0000) begin failures++; $display("FAIL midreset_spi_tx got=%h exp=0000", spi_tx); end
        checks++; if (frame_data !== '0) begin failures++; $display("FAIL midreset_frame_data got=%h exp=0", frame_data); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL midreset_frame_valid got=%0b exp=0", frame_valid); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL midreset_frame_count got=%0d exp=0", frame_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midreset_overrun got=%0b exp=0", overrun); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL midreset_timeout_err got=%0b exp=0", timeout_err); end
        rst_n = 1'b1;
        exp_count = 0;
        repeat (5) @(negedge clk);
        old = fv_count;
        xfer_n = 0;
        pulse_drdy(t);
        wait_frame(old, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midreset_frame_timeout got=no_frame_valid exp=frame_valid"); end
        exp_count = exp_count + 1;
        for (int i = 0; i < 7; i++) begin
            checks++; if (tx_log[i] !== exp_tx[i]) begin failures++; $display("FAIL midreset_spi_tx[%0d] got=%h exp=%h", i, tx_log[i], exp_tx[i]); end
        end
        for (int i = 0; i < NR; i++) begin
            checks++; if (frame_data[16*i +: 16] !== 16'h1001 + 16'(i)) begin failures++; $display("FAIL midreset_word[%0d] got=%h exp=%h", i, frame_data[16*i +: 16], 16'h1001 + 16'(i)); end
        end
        checks++; if (frame_count !== 16'(exp_count)) begin failures++; $display("FAIL midreset_frame_count_after got=%0d exp=%0d", frame_count, exp_count); end
        $display("frame: after mid-frame reset count=%0d", frame_count);
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_timeout();
        test_enable_drop();
        test_enable_off();
        test_midframe_reset();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
